// File: rtl/tia_poly_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tia_poly_counter
//  Description : Parametrised XNOR-LFSR polynomial counter with terminal-state
//                reload, resync request, count enable, sticky lock-up flag
//                and registered per-channel state decodes.
//  Revision    : 1.0  initial release
// ============================================================================
module tia_poly_counter #(
   parameter int                         WIDTH      = 6,
   parameter int                         TAP        = 4,
   parameter logic [WIDTH-1:0]           WRAP       = 6'b010100,
   parameter int                         NUM_DEC    = 4,
   parameter logic [NUM_DEC*WIDTH-1:0]   DEC_VALUES = {NUM_DEC{6'b000000}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               rsyn,
   output logic [WIDTH-1:0]   out,
   output logic               shb,
   output logic               rsynd,
   output logic               err,
   output logic [NUM_DEC-1:0] dec
);

   logic [WIDTH-1:0]   r_out;
   logic               r_shb;
   logic               r_rsynd;
   logic               r_err;
   logic [NUM_DEC-1:0] r_dec;

   logic               w_fb;
   logic               w_all_ones;
   logic               w_req;
   logic [WIDTH-1:0]   w_next;
   logic [NUM_DEC-1:0] w_hit;

   // XNOR feedback: all-ones maps to itself, which is why it needs forced recovery
   assign w_fb       = ~(r_out[WIDTH-1] ^ r_out[TAP]);
   assign w_all_ones = &r_out;

   // Terminal state, lock-up and resync all share the single reload path
   assign w_req      = (r_out == WRAP) | w_all_ones | rsyn;

   // A reload flagged on the previous enabled edge takes priority over the shift
   assign w_next     = r_shb ? '0 : {r_out[WIDTH-2:0], w_fb};

   // One equality comparator per decode channel, all against the pre-edge state
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DEC; gi = gi + 1) begin : g_dec
         assign w_hit[gi] = (r_out == DEC_VALUES[gi*WIDTH +: WIDTH]);
      end
   endgenerate

   // Counter, reload flag, resync delay, decodes and lock-up flag; all hold when en=0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out   <= '0;
         r_shb   <= 1'b0;
         r_rsynd <= 1'b0;
         r_err   <= 1'b0;
         r_dec   <= '0;
      end else if (en) begin
         r_shb   <= w_req;
         r_rsynd <= rsyn;
         r_out   <= w_next;
         r_dec   <= w_hit;
         r_err   <= r_err | w_all_ones;
      end
   end

   assign out   = r_out;
   assign shb   = r_shb;
   assign rsynd = r_rsynd;
   assign err   = r_err;
   assign dec   = r_dec;

endmodule
`default_nettype wire
